// File: rtl/sample_buffer_pkg.sv
// Shared types and constants for the elastic stereo sample buffer.
package sample_buffer_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DEF_WIDTH   = 24;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_PREFILL = 8;

  // Width of the optional underrun/overrun event counters.
  localparam int STAT_WIDTH  = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (v == {STAT_WIDTH{1'b1}}) ? v : v + STAT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/sample_buffer_mem.sv
// Stereo pair storage: one write port, one registered read port.
// The read register doubles as the output holding register, so it can also
// be cleared to zero; it keeps its value whenever neither re_i nor clr_i is set.
module sample_buffer_mem #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [2*WIDTH-1:0] wdata_i,
  input  logic               re_i,
  input  logic               clr_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [2*WIDTH-1:0] rdata_o
);

  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [2*WIDTH-1:0] rdata_q;

  // Storage array write; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read: a same-cycle write to the read address returns the old pair.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sample_buffer.sv
// Elastic stereo sample buffer between the S/PDIF decoder and the I2S transmitter.
// Optional feature macro: SAMPLE_BUFFER_STATS_EN adds saturating 16-bit
// underrun_count / overrun_count outputs.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_FILL | outputs 0, requests ignored, waiting for level >= PREFILL
// ST_RUN  | each request pops one pair; a request while empty -> ST_FILL
module sample_buffer
  import sample_buffer_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int PREFILL = DEF_PREFILL
) (
  input  logic                     bclk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_left,
  input  logic [WIDTH-1:0]         in_right,
  input  logic                     next_sample,
  output logic [WIDTH-1:0]         sample_left,
  output logic [WIDTH-1:0]         sample_right,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     running,
  output logic                     underrun,
  output logic                     overrun
`ifdef SAMPLE_BUFFER_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]    underrun_count,
  output logic [STAT_WIDTH-1:0]    overrun_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
  localparam logic [LW-1:0] PREFILL_L = LW'(PREFILL);

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;
  logic            underrun_q, overrun_q;
  logic            pop, req_empty, wr_en;
  logic [2*WIDTH-1:0] rdata;

  // Decode a transmitter request and decide whether the incoming pair fits.
  always_comb begin
    pop       = 1'b0;
    req_empty = 1'b0;
    if (state_q == ST_RUN && next_sample) begin
      if (level_q != '0) pop = 1'b1;
      else               req_empty = 1'b1;
    end
    // A pop in the same cycle frees a slot, so a full buffer can still accept.
    wr_en = in_valid && ((level_q != DEPTH_L) || pop);
  end

  // Occupancy counter next value.
  always_comb begin
    level_d = level_q;
    unique case ({wr_en, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Next-state logic; the FILL exit looks at the registered level.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FILL: if (level_q >= PREFILL_L) state_d = ST_RUN;
      ST_RUN:  if (req_empty)            state_d = ST_FILL;
      default: state_d = ST_FILL;
    endcase
  end

  // State, pointers, level and event pulses.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      underrun_q <= req_empty;
      overrun_q  <= in_valid && !wr_en;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  sample_buffer_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (bclk),
    .rst_ni  (rst_n),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i ({in_left, in_right}),
    .re_i    (pop),
    .clr_i   (req_empty),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign {sample_left, sample_right} = rdata;
  assign level    = level_q;
  assign running  = (state_q == ST_RUN);
  assign underrun = underrun_q;
  assign overrun  = overrun_q;

`ifdef SAMPLE_BUFFER_STATS_EN
  logic [STAT_WIDTH-1:0] underrun_cnt_q, overrun_cnt_q;

  // Saturating event counters, counted from the same events that set the pulses.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt_q <= '0;
      overrun_cnt_q  <= '0;
    end else begin
      if (req_empty)            underrun_cnt_q <= sat_inc(underrun_cnt_q);
      if (in_valid && !wr_en)   overrun_cnt_q  <= sat_inc(overrun_cnt_q);
    end
  end

  assign underrun_count = underrun_cnt_q;
  assign overrun_count  = overrun_cnt_q;
`endif

endmodule
